pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised inter-stage pipeline register: the generalised successor of the fixed IF/ID register.
//  - Payload is a packed struct flattened to WIDTH bits, plus a valid bit.
//  - Carries a LATE field (e.g. an instruction from BRAM) whose source is already registered.
//    It passes through combinationally, and is captured internally during stalls so it survives
//    the stall even though the BRAM output changes.
//  - Sits between any two core stages (IF/ID, ID/EX, ...). Flush inserts a bubble, stall freezes the stage.
// PARAMETERS
//  WIDTH     64            payload (struct) width, bits
//  LATE_W    32            late-arriving field width, bits
//  NOP_VALUE 32'h00000013  value driven on late_o when flushed/reset (RISC-V addi x0,x0,0); LATE_W bits
// PORTS
//  clk          in   1        clock; all state updates on posedge
//  rst          in   1        synchronous, active-high reset
//  flush        in   1        kill stage contents (bubble)
//  stall        in   1        hold stage contents
//  valid_i      in   1        upstream payload valid
//  d_i          in   WIDTH    upstream payload
//  late_i       in   LATE_W   late field, registered at source (BRAM dout)
//  valid_o      out  1        stage valid
//  q_o          out  WIDTH    registered payload
//  late_o       out  LATE_W   late field aligned with q_o
//  holding_o    out  1        1 = late_o is sourced from the internal hold register
//  stall_cnt_o  out  32       stall-cycle counter (perf; see CONFIGURATION)
//  flush_cnt_o  out  32       flush-event counter (perf; see CONFIGURATION)
// BEHAVIOUR
//  - Priority at each posedge: rst > flush > stall > load.
//  - Reset values:
//    - q_o=0, valid_o=0, hold_q=0, state=PASS.
//    - late_o=NOP_VALUE while rst=1; counters=0.
//  - Load (no rst/flush/stall): q_o<=d_i and valid_o<=valid_i. Latency is 1 cycle.
//  - Flush: q_o<=0 and valid_o<=0 at the edge.
//    - late_o=NOP_VALUE combinationally in the same cycle as flush, in any state.
//    - state<=PASS.
//  - Stall without flush: q_o and valid_o hold their values.
//  - Late-field FSM, two states:
//    - PASS: late_o=late_i.
//      - stall && !flush: hold_q<=late_i, state<=HOLD.
//    - HOLD: late_o=hold_q, holding_o=1.
//      - flush or !stall: state<=PASS.
//      - The cycle in which stall drops still outputs hold_q, and q_o loads d_i at that edge.
//      - Stall held: stay in HOLD; hold_q is not re-captured.
//  - flush && stall together: flush wins. Bubble inserted, FSM->PASS, no capture.
//  - Reset mid-HOLD: returns to PASS next cycle and hold_q is cleared.
//  - late_o is the only combinational path: flush/state/late_i -> late_o. q_o and valid_o are pure flops.
// CONFIGURATION
//  - Macro PIPE_STAGE_PERF_EN, when defined:
//    - stall_cnt_o increments on every cycle with stall && !flush && !rst.
//    - flush_cnt_o increments on every cycle with flush && !rst.
//    - Both wrap modulo 2^32 and reset to 0.
//  - Undefined: both ports are tied to 32'h0 and no counter flops are built. The port list is identical either way.
// TESTING
//  1. rst=1 for 2 cycles -> valid_o=0, q_o=0, late_o=32'h13, holding_o=0. Release, then d_i=64'hA5, valid_i=1 -> next cycle q_o=64'hA5, valid_o=1.
//  2. Load q_o=64'h1; stall 3 cycles with late_i=32'hDEAD then 32'hBEEF, 32'h1234 -> late_o: DEAD, DEAD, DEAD; q_o=64'h1 throughout; holding_o=0,1,1.
//  3. Stall drops after case 2 with d_i=64'h2 -> that cycle late_o=DEAD, holding_o=1. Next cycle q_o=64'h2, late_o=late_i, holding_o=0.
//  4. flush=1 with stall=1 while in HOLD -> same cycle late_o=32'h13. Next cycle valid_o=0, q_o=0, holding_o=0.
//  5. rst asserted during HOLD -> next cycle holding_o=0, late_o=32'h13 while rst is high, and hold_q=0 (check via stall-free release).
//  6. PIPE_STAGE_PERF_EN defined: 5 stall cycles + 2 flush cycles -> stall_cnt_o=5, flush_cnt_o=2. Undefined: both read 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with a stall-safe late-arriving field.
// Optional perf counters are built only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg #(
    parameter int unsigned         WIDTH     = 64,
    parameter int unsigned         LATE_W    = 32,
    parameter logic [LATE_W-1:0]   NOP_VALUE = 'h13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall,
    input  logic              valid_i,
    input  logic [WIDTH-1:0]  d_i,
    input  logic [LATE_W-1:0] late_i,
    output logic              valid_o,
    output logic [WIDTH-1:0]  q_o,
    output logic [LATE_W-1:0] late_o,
    output logic              holding_o,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
);

    typedef enum logic {PASS, HOLD} state_e;

    state_e              state_q, state_d;
    logic                valid_q, valid_d;
    logic [WIDTH-1:0]    payload_q, payload_d;
    logic [LATE_W-1:0]   hold_q, hold_d;

    // Flush beats stall beats load; the late field is captured only on stall entry.
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        payload_d = payload_q;
        hold_d    = hold_q;
        if (flush) begin
            valid_d   = 1'b0;
            payload_d = '0;
            state_d   = PASS;
        end else if (stall) begin
            if (state_q == PASS) begin
                hold_d  = late_i;
                state_d = HOLD;
            end
        end else begin
            valid_d   = valid_i;
            payload_d = d_i;
            state_d   = PASS;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= PASS;
            valid_q   <= 1'b0;
            payload_q <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            payload_q <= payload_d;
            hold_q    <= hold_d;
        end
    end

    // The BRAM output is already registered at its source, so only the mux sits on this path.
    assign late_o    = (rst || flush) ? NOP_VALUE :
                       (state_q == HOLD) ? hold_q : late_i;
    assign holding_o = (state_q == HOLD);
    assign valid_o   = valid_q;
    assign q_o       = payload_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stallCnt_q;
    logic [31:0] flushCnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt_q <= 32'd0;
            flushCnt_q <= 32'd0;
        end else begin
            if (stall && !flush) stallCnt_q <= stallCnt_q + 32'd1;
            if (flush)           flushCnt_q <= flushCnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stallCnt_q;
    assign flush_cnt_o = flushCnt_q;
`else
    assign stall_cnt_o = 32'h0;
    assign flush_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: per-cycle vector table plus a perf-counter sequence.
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        stall;
    logic        valid_i;
    logic [63:0] d_i;
    logic [31:0] late_i;
    logic        valid_o;
    logic [63:0] q_o;
    logic [31:0] late_o;
    logic        holding_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;

    int vecCount  = 0;
    int missCount = 0;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        stall;
        logic        valid;
        logic [63:0] d;
        logic [31:0] late;
        logic        expValid;
        logic [63:0] expQ;
        logic [31:0] expLate;
        logic        expHold;
        logic        chkHold;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    pipe_stage_reg #(
        .WIDTH     (64),
        .LATE_W    (32),
        .NOP_VALUE (32'h00000013)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .stall       (stall),
        .valid_i     (valid_i),
        .d_i         (d_i),
        .late_i      (late_i),
        .valid_o     (valid_o),
        .q_o         (q_o),
        .late_o      (late_o),
        .holding_o   (holding_o),
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic f, input logic s, input logic v,
                                input logic [63:0] d, input logic [31:0] l,
                                input logic ev, input logic [63:0] eq, input logic [31:0] el,
                                input logic eh, input logic ch);
        vec_t t;
        t.rst = r; t.flush = f; t.stall = s; t.valid = v; t.d = d; t.late = l;
        t.expValid = ev; t.expQ = eq; t.expLate = el; t.expHold = eh; t.chkHold = ch;
        return t;
    endfunction

    task automatic applyStimulus(input logic r, input logic f, input logic s, input logic v,
                                 input logic [63:0] d, input logic [31:0] l);
        rst = r; flush = f; stall = s; valid_i = v; d_i = d; late_i = l;
    endtask

    task automatic checkOutput(input string name, input logic ev, input logic [63:0] eq,
                               input logic [31:0] el, input logic eh, input logic ch);
        vecCount++;
        if (valid_o !== ev || q_o !== eq || late_o !== el || (ch && holding_o !== eh)) begin
            missCount++;
            $display("[TB] FAIL %s: got valid=%0b q=%h late=%h hold=%0b, expected valid=%0b q=%h late=%h hold=%0b",
                     name, valid_o, q_o, late_o, holding_o, ev, eq, el, eh);
        end
    endtask

    task automatic checkCount(input string name, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // One cycle: inputs are live from just after a posedge, outputs sampled at the negedge.
    task automatic runCycle(input logic r, input logic f, input logic s, input logic v,
                            input logic [63:0] d, input logic [31:0] l);
        applyStimulus(r, f, s, v, d, l);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] expStall;
        logic [31:0] expFlush;

        //                 rst f  s  v  d                      late          eV q                      eLate         eH chkH
        vecs[0]  = mk(1, 0, 0, 0, 64'h0,                 32'h00000077, 0, 64'h0,                 32'h00000013, 0, 1);
        vecs[1]  = mk(1, 0, 0, 0, 64'h0,                 32'h00000077, 0, 64'h0,                 32'h00000013, 0, 1);
        vecs[2]  = mk(0, 0, 0, 1, 64'hA5,                32'h00000011, 0, 64'h0,                 32'h00000011, 0, 1);
        vecs[3]  = mk(0, 0, 0, 1, 64'h1,                 32'h00000022, 1, 64'hA5,                32'h00000022, 0, 1);
        vecs[4]  = mk(0, 0, 1, 0, 64'h99,                32'h0000DEAD, 1, 64'h1,                 32'h0000DEAD, 0, 1);
        vecs[5]  = mk(0, 0, 1, 0, 64'h99,                32'h0000BEEF, 1, 64'h1,                 32'h0000DEAD, 1, 1);
        vecs[6]  = mk(0, 0, 1, 0, 64'h99,                32'h00001234, 1, 64'h1,                 32'h0000DEAD, 1, 1);
        vecs[7]  = mk(0, 0, 0, 1, 64'h2,                 32'h00005555, 1, 64'h1,                 32'h0000DEAD, 1, 1);
        vecs[8]  = mk(0, 0, 0, 1, 64'h3,                 32'h00006666, 1, 64'h2,                 32'h00006666, 0, 1);
        vecs[9]  = mk(0, 0, 1, 1, 64'h4,                 32'h0000AAAA, 1, 64'h3,                 32'h0000AAAA, 0, 1);
        vecs[10] = mk(0, 1, 1, 1, 64'h5,                 32'h0000BBBB, 1, 64'h3,                 32'h00000013, 0, 0);
        vecs[11] = mk(0, 0, 0, 1, 64'h7,                 32'h0000CCCC, 0, 64'h0,                 32'h0000CCCC, 0, 1);
        vecs[12] = mk(0, 0, 0, 1, 64'h8,                 32'h00000001, 1, 64'h7,                 32'h00000001, 0, 1);
        vecs[13] = mk(0, 0, 1, 0, 64'h0,                 32'h0000DDDD, 1, 64'h8,                 32'h0000DDDD, 0, 1);
        vecs[14] = mk(0, 0, 1, 0, 64'h0,                 32'h0000EEEE, 1, 64'h8,                 32'h0000DDDD, 1, 1);
        vecs[15] = mk(1, 0, 1, 0, 64'h0,                 32'h0000FFFF, 1, 64'h8,                 32'h00000013, 0, 0);
        vecs[16] = mk(0, 0, 0, 0, 64'h0,                 32'h00001357, 0, 64'h0,                 32'h00001357, 0, 1);
        vecs[17] = mk(0, 1, 0, 1, 64'h9,                 32'h00002468, 0, 64'h0,                 32'h00000013, 0, 1);
        vecs[18] = mk(0, 0, 0, 1, 64'hFFFFFFFFFFFFFFFF,  32'h00000000, 0, 64'h0,                 32'h00000000, 0, 1);
        vecs[19] = mk(0, 0, 0, 0, 64'h0,                 32'h0000ABCD, 1, 64'hFFFFFFFFFFFFFFFF,  32'h0000ABCD, 0, 1);
        vecs[20] = mk(0, 0, 0, 0, 64'h0,                 32'h0000ABCD, 0, 64'h0,                 32'h0000ABCD, 0, 1);

        applyStimulus(1, 0, 0, 0, 64'h0, 32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            runCycle(vecs[i].rst, vecs[i].flush, vecs[i].stall, vecs[i].valid, vecs[i].d, vecs[i].late);
            checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expQ,
                        vecs[i].expLate, vecs[i].expHold, vecs[i].chkHold);
            @(posedge clk);
            #1;
        end

        // Perf counters: reset, 5 stalls (one with flush too, which must not count as a stall), 2 flushes.
`ifdef PIPE_STAGE_PERF_EN
        expStall = 32'd5;
        expFlush = 32'd2;
`else
        expStall = 32'd0;
        expFlush = 32'd0;
`endif
        runCycle(1, 0, 1, 0, 64'h0, 32'h0);
        @(posedge clk); #1;
        runCycle(0, 0, 0, 0, 64'h0, 32'h0);
        checkCount("stall_cnt_reset", stall_cnt_o, 32'd0);
        checkCount("flush_cnt_reset", flush_cnt_o, 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            runCycle(0, 0, 1, 1, 64'(i), 32'h100 + 32'(i));
            @(posedge clk); #1;
        end
        runCycle(0, 1, 1, 0, 64'h0, 32'h0);
        @(posedge clk); #1;
        runCycle(0, 1, 0, 0, 64'h0, 32'h0);
        @(posedge clk); #1;
        runCycle(0, 0, 0, 0, 64'h0, 32'h0);
        checkCount("stall_cnt", stall_cnt_o, expStall);
        checkCount("flush_cnt", flush_cnt_o, expFlush);
        checkOutput("after_perf_flush", 1'b0, 64'h0, 32'h0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
